commit_monitor: RTL and testbench

Retire-side difftest front end for the NPC core. The core pushes one record per retired instruction into `commit_monitor`. The block keeps the records in a small FIFO and maintains a shadow GPR file that is updated only when the checker takes a record. Records are presented to the simulation checker through a valid/ready handshake. On `ebreak` the block drains the FIFO, then raises `halt` with the exit code from a0, which ends the DUT→checker commit stream.

---
 rtl/difftest_pkg.sv | 24 ++
 rtl/commit_fifo.sv | 46 ++++
 rtl/commit_monitor.sv | 107 ++++++++++
 tb/tb_commit_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared types for the retire-side difftest front end: commit record, monitor state, GPR constants.
package difftest_pkg;

  localparam int GPR_NUM  = 32;
  localparam int A0_IDX   = 10;
  // Record storage width; the monitor zero-extends narrower XLEN values into it.
  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         inst;
    logic                wen;
    logic [4:0]          wdest;
    logic [XLEN_MAX-1:0] wdata;
    logic                brk;
  } commit_rec_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit records; write visible at the head one cycle later, no fall-through.
// Writes while full and reads while empty are ignored; a same-cycle read never frees a slot for the write.
module commit_fifo
  import difftest_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_en,
  input  commit_rec_t wr_dat,
  input  logic        rd_en,
  output commit_rec_t rd_dat,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  commit_rec_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/commit_monitor.sv
// Retire-side difftest front end: queues commit records, updates a shadow GPR file on checker dequeue,
// drains and halts on ebreak. Enqueue-to-checker latency 1 cycle; cmt_ready drops when full or after ebreak.
module commit_monitor
  import difftest_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            cmt_valid,
  output logic            cmt_ready,
  input  logic [XLEN-1:0] cmt_pc,
  input  logic [31:0]     cmt_inst,
  input  logic            cmt_wen,
  input  logic [4:0]      cmt_wdest,
  input  logic [XLEN-1:0] cmt_wdata,
  input  logic            cmt_break,
  output logic            chk_valid,
  input  logic            chk_ready,
  output logic [XLEN-1:0] chk_pc,
  output logic [31:0]     chk_inst,
  output logic            chk_wen,
  output logic [4:0]      chk_wdest,
  output logic [XLEN-1:0] chk_wdata,
  output logic            chk_break,
  input  logic [4:0]      gpr_raddr,
  output logic [XLEN-1:0] gpr_rdata,
  output logic [XLEN-1:0] commit_cnt,
  output logic            halt,
  output logic [XLEN-1:0] halt_code
);

  mon_state_e      state;
  commit_rec_t     enq_rec;
  commit_rec_t     head;
  logic            full;
  logic            empty;
  logic            enq;
  logic            deq;
  logic [XLEN-1:0] shadow [GPR_NUM];
  logic [XLEN-1:0] a0_next;

  assign cmt_ready = (state == RUN) && !full;
  assign chk_valid = !empty && (state != HALT);
  assign enq       = cmt_valid && cmt_ready;
  assign deq       = chk_valid && chk_ready;

  always_comb begin
    enq_rec       = '0;
    enq_rec.pc    = XLEN_MAX'(cmt_pc);
    enq_rec.inst  = cmt_inst;
    enq_rec.wen   = cmt_wen;
    enq_rec.wdest = cmt_wdest;
    enq_rec.wdata = XLEN_MAX'(cmt_wdata);
    enq_rec.brk   = cmt_break;
  end

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (enq),
    .wr_dat  (enq_rec),
    .rd_en   (deq),
    .rd_dat  (head),
    .full    (full),
    .empty   (empty)
  );

  assign chk_pc    = head.pc[XLEN-1:0];
  assign chk_inst  = head.inst;
  assign chk_wen   = head.wen;
  assign chk_wdest = head.wdest;
  assign chk_wdata = head.wdata[XLEN-1:0];
  assign chk_break = head.brk;

  assign gpr_rdata = (gpr_raddr == 5'd0) ? '0 : shadow[gpr_raddr];

  // a0 as it will be after this cycle's write, so an ebreak that itself writes a0 reports that value.
  assign a0_next = (chk_wen && chk_wdest == 5'(A0_IDX)) ? chk_wdata : shadow[A0_IDX];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      commit_cnt <= '0;
      halt       <= 1'b0;
      halt_code  <= '0;
      for (int i = 0; i < GPR_NUM; i++)
        shadow[i] <= '0;
    end else begin
      if (enq && cmt_break)
        state <= DRAIN;
      if (deq) begin
        if (chk_wen && chk_wdest != 5'd0)
          shadow[chk_wdest] <= chk_wdata;
        commit_cnt <= commit_cnt + XLEN'(1);
        // Enqueue stops at the ebreak, so it is always the last record drained.
        if (state == DRAIN && chk_break) begin
          state     <= HALT;
          halt      <= 1'b1;
          halt_code <= a0_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: vector table of single-record commits plus backpressure, ebreak and reset sequences.
module tb_commit_monitor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmt_valid, cmt_ready;
  logic [63:0] cmt_pc;
  logic [31:0] cmt_inst;
  logic        cmt_wen;
  logic [4:0]  cmt_wdest;
  logic [63:0] cmt_wdata;
  logic        cmt_break;
  logic        chk_valid, chk_ready;
  logic [63:0] chk_pc;
  logic [31:0] chk_inst;
  logic        chk_wen;
  logic [4:0]  chk_wdest;
  logic [63:0] chk_wdata;
  logic        chk_break;
  logic [4:0]  gpr_raddr;
  logic [63:0] gpr_rdata, commit_cnt;
  logic        halt;
  logic [63:0] halt_code;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  commit_monitor #(.DEPTH(4), .XLEN(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
    .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata), .cmt_break(cmt_break),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_pc(chk_pc), .chk_inst(chk_inst),
    .chk_wen(chk_wen), .chk_wdest(chk_wdest), .chk_wdata(chk_wdata), .chk_break(chk_break),
    .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata), .commit_cnt(commit_cnt),
    .halt(halt), .halt_code(halt_code)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic [4:0]  exp_idx;
    logic [63:0] exp_val;
    logic [63:0] exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic wen, input logic [4:0] wdest,
                       input logic [63:0] wdata, input logic brk);
    cmt_pc    = pc;
    cmt_inst  = brk ? 32'h0010_0073 : 32'h0000_0013;
    cmt_wen   = wen;
    cmt_wdest = wdest;
    cmt_wdata = wdata;
    cmt_break = brk;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64'h8000_0000, 32'h0000_0013, 1'b1, 5'd5,  64'h1234, 5'd5,  64'h1234, 64'd1};
    vecs[1] = '{64'h8000_0004, 32'h0000_0093, 1'b1, 5'd0,  64'hFFFF, 5'd0,  64'h0,    64'd2};
    vecs[2] = '{64'h8000_0008, 32'h0000_0113, 1'b0, 5'd6,  64'hDEAD, 5'd6,  64'h0,    64'd3};
    vecs[3] = '{64'h8000_000C, 32'h0000_0193, 1'b1, 5'd5,  64'hABCD, 5'd5,  64'hABCD, 64'd4};
    vecs[4] = '{64'h8000_0010, 32'h0000_0213, 1'b1, 5'd31, '1,       5'd31, '1,       64'd5};
    vecs[5] = '{64'h8000_0014, 32'h0000_0293, 1'b1, 5'd10, 64'h55,   5'd10, 64'h55,   64'd6};

    reset_n = 1'b0; cmt_valid = 1'b0; chk_ready = 1'b0; gpr_raddr = '0;
    drive(64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("rst_cmt_ready", cmt_ready, 1);
    check("rst_chk_valid", chk_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_commit_cnt", commit_cnt, 0);
    for (int i = 0; i < 32; i++) begin
      gpr_raddr = 5'(i);
      #0.1;
      check($sformatf("rst_gpr%0d", i), gpr_rdata, 0);
    end
    tick();

    // Single-record commits: enqueue, observe head, dequeue, observe shadow and counter.
    for (int v = 0; v < 6; v++) begin
      cmt_pc = vecs[v].pc; cmt_inst = vecs[v].inst; cmt_wen = vecs[v].wen;
      cmt_wdest = vecs[v].wdest; cmt_wdata = vecs[v].wdata; cmt_break = 1'b0;
      cmt_valid = 1'b1;
      #1;
      check($sformatf("v%0d_no_fallthrough", v), chk_valid, 0);
      tick();
      cmt_valid = 1'b0;
      #1;
      check($sformatf("v%0d_chk_valid", v), chk_valid, 1);
      check($sformatf("v%0d_chk_pc", v), chk_pc, vecs[v].pc);
      check($sformatf("v%0d_chk_inst", v), chk_inst, vecs[v].inst);
      check($sformatf("v%0d_chk_wdata", v), chk_wdata, vecs[v].wdata);
      gpr_raddr = vecs[v].exp_idx;
      chk_ready = 1'b1;
      tick();
      chk_ready = 1'b0;
      #1;
      check($sformatf("v%0d_empty_after", v), chk_valid, 0);
      check($sformatf("v%0d_gpr", v), gpr_rdata, vecs[v].exp_val);
      check($sformatf("v%0d_cnt", v), commit_cnt, vecs[v].exp_cnt);
    end

    // Backpressure: fill 4 entries, fifth is refused, head holds, drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(64'(i * 4), 1'b0, 5'd0, 64'h0, 1'b0);
      cmt_valid = 1'b1;
      #1;
      check($sformatf("bp_ready%0d", i), cmt_ready, 1);
      tick();
    end
    drive(64'h10, 1'b0, 5'd0, 64'h0, 1'b0);
    #1;
    check("bp_full_ready", cmt_ready, 0);
    tick();
    cmt_valid = 1'b0;
    #1;
    check("bp_hold_valid", chk_valid, 1);
    check("bp_hold_pc", chk_pc, 64'h0);
    chk_ready = 1'b1;
    #1;
    check("bp_no_same_cycle_slot", cmt_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_drain_valid%0d", i), chk_valid, 1);
      check($sformatf("bp_drain_pc%0d", i), chk_pc, 64'(i * 4));
      tick();
    end
    chk_ready = 1'b0;
    #1;
    check("bp_empty", chk_valid, 0);
    check("bp_cnt", commit_cnt, 64'd10);

    // ebreak with two records ahead, the first setting a0=42.
    drive(64'h100, 1'b1, 5'd10, 64'd42, 1'b0);
    cmt_valid = 1'b1;
    #1 check("eb_ready0", cmt_ready, 1);
    tick();
    drive(64'h104, 1'b0, 5'd0, 64'h0, 1'b0);
    #1 check("eb_ready1", cmt_ready, 1);
    tick();
    drive(64'h108, 1'b0, 5'd0, 64'h0, 1'b1);
    #1 check("eb_ready2", cmt_ready, 1);
    tick();
    drive(64'h10C, 1'b0, 5'd0, 64'h0, 1'b0);
    #1 check("eb_drain_ready", cmt_ready, 0);
    tick();
    cmt_valid = 1'b0;
    chk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("eb_pc%0d", i), chk_pc, 64'h100 + 64'(i * 4));
      check($sformatf("eb_halt_low%0d", i), halt, 0);
      tick();
    end
    #1;
    check("eb_halt", halt, 1);
    check("eb_halt_code", halt_code, 64'd42);
    check("eb_chk_valid", chk_valid, 0);
    check("eb_cnt", commit_cnt, 64'd13);
    repeat (2) tick();
    gpr_raddr = 5'd10;
    #1;
    check("eb_valid_stays_low", chk_valid, 0);
    check("eb_halt_stays", halt, 1);
    check("eb_ready_stays_low", cmt_ready, 0);
    check("eb_gpr_a0", gpr_rdata, 64'd42);
    chk_ready = 1'b0;

    // Reset out of HALT, then reset again while draining with 3 entries queued.
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    check("rr_ready", cmt_ready, 1);
    check("rr_halt", halt, 0);
    check("rr_cnt", commit_cnt, 0);
    drive(64'h180, 1'b1, 5'd3, 64'd9, 1'b0);
    cmt_valid = 1'b1;
    tick();
    cmt_valid = 1'b0;
    chk_ready = 1'b1;
    tick();
    chk_ready = 1'b0;
    gpr_raddr = 5'd3;
    #1;
    check("rr_cnt1", commit_cnt, 64'd1);
    check("rr_gpr3", gpr_rdata, 64'd9);
    for (int i = 0; i < 3; i++) begin
      drive(64'h190 + 64'(i * 4), 1'b0, 5'd0, 64'h0, (i == 2));
      cmt_valid = 1'b1;
      tick();
    end
    cmt_valid = 1'b0;
    #1;
    check("rd_in_drain_ready", cmt_ready, 0);
    check("rd_in_drain_valid", chk_valid, 1);
    reset_n = 1'b0;
    #1;
    check("rd_valid_drop", chk_valid, 0);
    check("rd_cnt_zero", commit_cnt, 0);
    check("rd_gpr3_zero", gpr_rdata, 0);
    check("rd_ready_back", cmt_ready, 1);
    #2 reset_n = 1'b1;
    tick();

    // ebreak that itself writes a0: halt_code must include that write.
    drive(64'h200, 1'b1, 5'd10, 64'd7, 1'b1);
    cmt_valid = 1'b1;
    #1 check("ea_ready", cmt_ready, 1);
    tick();
    cmt_valid = 1'b0;
    #1;
    check("ea_valid", chk_valid, 1);
    check("ea_pc", chk_pc, 64'h200);
    check("ea_brk", chk_break, 1);
    check("ea_drain_ready", cmt_ready, 0);
    chk_ready = 1'b1;
    tick();
    chk_ready = 1'b0;
    #1;
    check("ea_halt", halt, 1);
    check("ea_halt_code", halt_code, 64'd7);
    check("ea_cnt", commit_cnt, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
